// File: rtl/regfile_write_queue_if.sv
// ----------------------------------------------------------------------------
// regfile_write_queue_if
//   Bundles the signals around the register-file write queue.
//   Writeback side : wb_valid, wb_ready, wb_sel, wb_dat
//   Register port  : hold, WEN, wsel, wdat
//   Decode lookup  : lk_sel, lk_hit, lk_dat
//   Status         : count (occupied entries, $clog2(DEPTH)+1 bits)
//   Modports: slave  = the queue itself
//             master = the environment (writer, register file, decode)
// ----------------------------------------------------------------------------
interface regfile_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wb_valid;
    logic              wb_ready;
    logic [SEL_W-1:0]  wb_sel;
    logic [DATA_W-1:0] wb_dat;
    logic              hold;
    logic              WEN;
    logic [SEL_W-1:0]  wsel;
    logic [DATA_W-1:0] wdat;
    logic [SEL_W-1:0]  lk_sel;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_dat;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  wb_valid, wb_sel, wb_dat, hold, lk_sel,
        output wb_ready, WEN, wsel, wdat, lk_hit, lk_dat, count
    );

    modport master (
        output wb_valid, wb_sel, wb_dat, hold, lk_sel,
        input  wb_ready, WEN, wsel, wdat, lk_hit, lk_dat, count
    );
endinterface

// File: rtl/regfile_write_queue.sv
// ----------------------------------------------------------------------------
// regfile_write_queue
//   In-order DEPTH-entry write buffer in front of the register-file write
//   port. Accepts writeback requests by valid/ready, issues at most one write
//   per cycle (paused by hold) and offers decode a combinational lookup of the
//   youngest pending value for a register.
//
//   Ports:
//     CLK  - clock
//     RST  - synchronous active-high reset; discards all pending entries
//     bus  - regfile_write_queue_if.slave (writeback, write port, lookup,
//            count)
//
//   Optional build macro: WRQ_COALESCE_EN
//     When defined, a push to the same register as the tail-most pending
//     entry overwrites that entry's data instead of allocating a new one
//     (unless that entry is the head leaving this very cycle).
// ----------------------------------------------------------------------------
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5
) (
    input logic                   CLK,
    input logic                   RST,
    regfile_write_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [SEL_W-1:0]   sel_q [DEPTH];
    logic [DATA_W-1:0]  dat_q [DEPTH];

    logic               push_req;
    logic               alloc;
    logic               coalesce;
    logic               wen;

    // Issue side only looks at registered state and the live hold input, so
    // nothing on wb_* can reach WEN/wsel/wdat combinationally.
    assign wen          = (state_q != ST_EMPTY) && !bus.hold;
    assign bus.WEN      = wen;
    assign bus.wsel     = (state_q != ST_EMPTY) ? sel_q[head_q] : '0;
    assign bus.wdat     = (state_q != ST_EMPTY) ? dat_q[head_q] : '0;
    assign bus.count    = count_q;
    // No pass-through: a full queue refuses even if it pops this cycle.
    assign bus.wb_ready = (count_q < CNT_W'(DEPTH));

    // Register 0 writes complete the handshake but are dropped here.
    assign push_req = bus.wb_valid && bus.wb_ready && (bus.wb_sel != '0);

`ifdef WRQ_COALESCE_EN
    logic [PTR_W-1:0] tail_last;
    assign tail_last = tail_q - PTR_W'(1);
    // The tail-most entry is also the head only when count==1; if it is
    // leaving this cycle, merging into it would lose the new data.
    assign coalesce  = push_req && (count_q != '0)
                     && (sel_q[tail_last] == bus.wb_sel)
                     && !(wen && (count_q == CNT_W'(1)));
`else
    assign coalesce  = 1'b0;
`endif

    assign alloc = push_req && !coalesce;

    // Next-state: pointers, occupancy and FSM state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;

        if (wen)   head_d = head_q + PTR_W'(1);
        if (alloc) tail_d = tail_q + PTR_W'(1);

        if (alloc && !wen)      count_d = count_q + CNT_W'(1);
        else if (!alloc && wen) count_d = count_q - CNT_W'(1);

        // EMPTY tracks occupancy; HOLD/ACTIVE records whether the port was
        // stalled when the last non-empty cycle closed. WEN itself uses the
        // live hold so a release takes effect in the same cycle.
        if (count_d == '0)  state_d = ST_EMPTY;
        else if (bus.hold)  state_d = ST_HOLD;
        else                state_d = ST_ACTIVE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: only slots inside [head, head+count) are ever observed,
    // so the array needs no reset.
    always_ff @(posedge CLK) begin
        if (!RST && alloc) begin
            sel_q[tail_q] <= bus.wb_sel;
            dat_q[tail_q] <= bus.wb_dat;
        end
`ifdef WRQ_COALESCE_EN
        if (!RST && coalesce) begin
            dat_q[tail_last] <= bus.wb_dat;
        end
`endif
    end

    // Lookup: one comparator per age slot (0 = head, DEPTH-1 = youngest
    // possible), then the youngest matching slot supplies the data.
    logic [DEPTH-1:0]  age_match;
    logic [DATA_W-1:0] age_dat [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] idx;
            assign idx           = head_q + PTR_W'(gi);
            assign age_match[gi] = (CNT_W'(gi) < count_q)
                                 && (sel_q[idx] == bus.lk_sel)
                                 && (bus.lk_sel != '0);
            assign age_dat[gi]   = dat_q[idx];
        end
    endgenerate

    always_comb begin
        bus.lk_hit = 1'b0;
        bus.lk_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                bus.lk_hit = 1'b1;
                bus.lk_dat = age_dat[i];
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_queue
//   Directed vector table, a reset-mid-drain sequence and a randomized run
//   against a queue-based reference model of regfile_write_queue.
// ----------------------------------------------------------------------------
module tb_regfile_write_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 5;

`ifdef WRQ_COALESCE_EN
    localparam bit CO = 1'b1;
`else
    localparam bit CO = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    regfile_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] sel, input logic [31:0] dat,
                         input logic hold, input logic [4:0] lk);
        bus.wb_valid = v;
        bus.wb_sel   = sel;
        bus.wb_dat   = dat;
        bus.hold     = hold;
        bus.lk_sel   = lk;
    endtask

    // Called 1 time unit after a rising edge; lands 1 unit after the next.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  sel;
        logic [31:0] dat;
        logic        hold;
        logic [4:0]  lk;
        logic        e_wen;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_hit;
        logic [31:0] e_lkd;
    } vec_t;

    function automatic vec_t mk(logic v, logic [4:0] sel, logic [31:0] dat, logic hold,
                                logic [4:0] lk, logic e_wen, logic [4:0] e_wsel,
                                logic [31:0] e_wdat, logic e_rdy, logic [2:0] e_cnt,
                                logic e_hit, logic [31:0] e_lkd);
        vec_t r;
        r.v = v; r.sel = sel; r.dat = dat; r.hold = hold; r.lk = lk;
        r.e_wen = e_wen; r.e_wsel = e_wsel; r.e_wdat = e_wdat; r.e_rdy = e_rdy;
        r.e_cnt = e_cnt; r.e_hit = e_hit; r.e_lkd = e_lkd;
        return r;
    endfunction

    // Reference model: a plain queue of pending {sel, dat} pairs.
    typedef struct {
        logic [4:0]  sel;
        logic [31:0] dat;
    } ent_t;
    ent_t mq[$];

    initial begin
        vec_t tbl[22];

        // Test 2: single write, one-cycle latency
        tbl[0]  = mk(1, 2, 99,    0, 0,  0, 0,  0,     1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,     0, 2,  1, 2,  99,    1, 1, 1, 99);
        tbl[2]  = mk(0, 0, 0,     0, 2,  0, 0,  0,     1, 0, 0, 0);
        // Test 3: register 0 is accepted but dropped
        tbl[3]  = mk(1, 0, 99,    0, 0,  0, 0,  0,     1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0,     0, 0,  0, 0,  0,     1, 0, 0, 0);
        // Test 4: fill under hold, fifth push stalls, then four writes in order
        tbl[5]  = mk(1, 17, 12345, 1, 0, 0, 0,  0,     1, 0, 0, 0);
        tbl[6]  = mk(1, 31, 54321, 1, 0, 0, 17, 12345, 1, 1, 0, 0);
        tbl[7]  = mk(1, 5,  1,     1, 0, 0, 17, 12345, 1, 2, 0, 0);
        tbl[8]  = mk(1, 6,  2,     1, 0, 0, 17, 12345, 1, 3, 0, 0);
        tbl[9]  = mk(1, 7,  3,     1, 31, 0, 17, 12345, 0, 4, 1, 54321);
        tbl[10] = mk(1, 7,  3,     0, 0, 1, 17, 12345, 0, 4, 0, 0);
        tbl[11] = mk(0, 0,  0,     0, 0, 1, 31, 54321, 1, 3, 0, 0);
        tbl[12] = mk(0, 0,  0,     0, 0, 1, 5,  1,     1, 2, 0, 0);
        tbl[13] = mk(0, 0,  0,     0, 0, 1, 6,  2,     1, 1, 0, 0);
        tbl[14] = mk(0, 0,  0,     0, 7, 0, 0,  0,     1, 0, 0, 0);
        // Tests 5/6: duplicate select, youngest lookup, optional coalescing
        tbl[15] = mk(1, 9, 10,    1, 9,  0, 0,  0,     1, 0, 0, 0);
        tbl[16] = mk(1, 9, 20,    1, 9,  0, 9,  10,    1, 1, 1, 10);
        tbl[17] = mk(0, 0, 0,     1, 9,  0, 9,  CO ? 20 : 10, 1, CO ? 1 : 2, 1, 20);
        tbl[18] = mk(0, 0, 0,     1, 8,  0, 9,  CO ? 20 : 10, 1, CO ? 1 : 2, 0, 0);
        tbl[19] = mk(0, 0, 0,     0, 0,  1, 9,  CO ? 20 : 10, 1, CO ? 1 : 2, 0, 0);
        tbl[20] = CO ? mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0)
                     : mk(0, 0, 0, 0, 0, 1, 9, 20, 1, 1, 0, 0);
        tbl[21] = mk(0, 0, 0,     0, 0,  0, 0,  0,     1, 0, 0, 0);

        RST = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(posedge CLK); #1;
        tick();

        // Reset state
        chk("rst_wen",   32'(bus.WEN), 0);
        chk("rst_wsel",  32'(bus.wsel), 0);
        chk("rst_wdat",  bus.wdat, 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_ready", 32'(bus.wb_ready), 1);
        chk("rst_hit",   32'(bus.lk_hit), 0);
        RST = 1'b0;

        // Test 1: three entries under hold, one write, then reset mid-drain
        drive(1, 3, 33, 1, 0); tick();
        drive(1, 4, 44, 1, 0); tick();
        drive(1, 5, 55, 1, 0); tick();
        drive(0, 0, 0, 0, 4);
        #2 chk("t1_pre_wsel", 32'(bus.wsel), 3);
        tick();
        chk("t1_pre_count", 32'(bus.count), 2);
        RST = 1'b1;
        tick();
        chk("t1_wen",   32'(bus.WEN), 0);
        chk("t1_wsel",  32'(bus.wsel), 0);
        chk("t1_wdat",  bus.wdat, 0);
        chk("t1_count", 32'(bus.count), 0);
        chk("t1_ready", 32'(bus.wb_ready), 1);
        chk("t1_hit",   32'(bus.lk_hit), 0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2 chk("t1_no_write", 32'(bus.WEN), 0);
            tick();
        end
        $display("SEQ reset-mid-drain done");

        // Directed table
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].dat, tbl[i].hold, tbl[i].lk);
            #2;
            $display("VEC %0d v=%0d sel=%0d dat=%0d hold=%0d lk=%0d -> wen=%0d wsel=%0d wdat=%0d rdy=%0d cnt=%0d hit=%0d lkd=%0d",
                     i, tbl[i].v, tbl[i].sel, tbl[i].dat, tbl[i].hold, tbl[i].lk,
                     bus.WEN, bus.wsel, bus.wdat, bus.wb_ready, bus.count, bus.lk_hit, bus.lk_dat);
            chk($sformatf("vec%0d_wen", i),   32'(bus.WEN),      32'(tbl[i].e_wen));
            chk($sformatf("vec%0d_wsel", i),  32'(bus.wsel),     32'(tbl[i].e_wsel));
            chk($sformatf("vec%0d_wdat", i),  bus.wdat,          tbl[i].e_wdat);
            chk($sformatf("vec%0d_ready", i), 32'(bus.wb_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_count", i), 32'(bus.count),    32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_hit", i),   32'(bus.lk_hit),   32'(tbl[i].e_hit));
            chk($sformatf("vec%0d_lkdat", i), bus.lk_dat,        tbl[i].e_lkd);
            tick();
        end

        // Randomized run against the queue model (queue is empty here)
        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        v, hold, rst, exp_wen, exp_rdy, exp_hit, pop, co;
            logic [4:0]  sel, lk, exp_wsel;
            logic [31:0] dat, exp_wdat, exp_lkd;
            ent_t        e;

            v    = ($urandom_range(0, 9) < 6);
            sel  = 5'($urandom_range(0, 7));
            dat  = $urandom;
            hold = ($urandom_range(0, 9) < 3);
            lk   = 5'($urandom_range(0, 7));
            rst  = ($urandom_range(0, 199) == 0);
            drive(v, sel, dat, hold, lk);
            RST = rst;

            exp_wen  = (mq.size() != 0) && !hold;
            exp_wsel = (mq.size() != 0) ? mq[0].sel : 5'd0;
            exp_wdat = (mq.size() != 0) ? mq[0].dat : 32'd0;
            exp_rdy  = (mq.size() < DEPTH);
            exp_hit  = 1'b0;
            exp_lkd  = 32'd0;
            if (lk != 0) begin
                foreach (mq[k]) begin
                    if (mq[k].sel == lk) begin
                        exp_hit = 1'b1;
                        exp_lkd = mq[k].dat;
                    end
                end
            end

            #2;
            chk("rnd_wen",   32'(bus.WEN),      32'(exp_wen));
            chk("rnd_wsel",  32'(bus.wsel),     32'(exp_wsel));
            chk("rnd_wdat",  bus.wdat,          exp_wdat);
            chk("rnd_ready", 32'(bus.wb_ready), 32'(exp_rdy));
            chk("rnd_count", 32'(bus.count),    32'(mq.size()));
            chk("rnd_hit",   32'(bus.lk_hit),   32'(exp_hit));
            chk("rnd_lkdat", bus.lk_dat,        exp_lkd);
            if (exp_wen && !rst)
                $display("WR cyc=%0d sel=%0d dat=0x%08h", cyc, exp_wsel, exp_wdat);

            // Model update for this edge
            if (rst) begin
                mq.delete();
            end else begin
                pop = exp_wen;
                co  = 1'b0;
                if (v && exp_rdy && sel != 0) begin
                    if (CO && mq.size() > 0 && mq[$].sel == sel && !(pop && mq.size() == 1)) begin
                        mq[$].dat = dat;
                        co = 1'b1;
                    end
                end
                if (pop) void'(mq.pop_front());
                if (v && exp_rdy && sel != 0 && !co) begin
                    e.sel = sel;
                    e.dat = dat;
                    mq.push_back(e);
                end
            end
            tick();
        end
        RST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
